icache: RTL and testbench

//   Direct-mapped, read-only instruction cache between the decoder fetch port and the memory controller.

---
 rtl/icache_pkg.sv | 33 +++
 rtl/icache_array.sv | 45 ++++
 rtl/icache.sv | 139 +++++++++++++
 tb/tb_icache.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared geometry, address-field helpers and FSM encoding for the instruction cache.
// ICACHE_OFFSET_WIDTH / ICACHE_INDEX_WIDTH may be predefined to change the geometry.
`ifndef ICACHE_OFFSET_WIDTH
`define ICACHE_OFFSET_WIDTH 2
`endif
`ifndef ICACHE_INDEX_WIDTH
`define ICACHE_INDEX_WIDTH 4
`endif

package icache_pkg;
    localparam int OFFSET_WIDTH = `ICACHE_OFFSET_WIDTH;
    localparam int INDEX_WIDTH  = `ICACHE_INDEX_WIDTH;
    localparam int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH;
    localparam int LINES        = 1 << INDEX_WIDTH;
    localparam int WORDS        = 1 << OFFSET_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_e;

    function automatic logic [OFFSET_WIDTH-1:0] addr_offset(input logic [31:0] a);
        return a[OFFSET_WIDTH+1:2];
    endfunction

    function automatic logic [INDEX_WIDTH-1:0] addr_index(input logic [31:0] a);
        return a[OFFSET_WIDTH+INDEX_WIDTH+1:OFFSET_WIDTH+2];
    endfunction

    function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [31:0] a);
        return a[31 -: TAG_WIDTH];
    endfunction
endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: combinational read, synchronous writes,
// valid bits cleared synchronously on rst_in.
module icache_array
    import icache_pkg::*;
(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [INDEX_WIDTH-1:0]  rd_index,
    input  logic [OFFSET_WIDTH-1:0] rd_offset,
    output logic                    rd_valid,
    output logic [TAG_WIDTH-1:0]    rd_tag,
    output logic [31:0]             rd_word,
    input  logic                    wr_word_en,
    input  logic [INDEX_WIDTH-1:0]  wr_index,
    input  logic [OFFSET_WIDTH-1:0] wr_offset,
    input  logic [31:0]             wr_word,
    input  logic                    wr_line_en,
    input  logic [TAG_WIDTH-1:0]    wr_tag
);
    logic [LINES-1:0]     valid_q;
    logic [TAG_WIDTH-1:0] tag_q  [LINES];
    logic [31:0]          data_q [LINES][WORDS];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (wr_line_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data need no reset: nothing is trusted until its valid bit is set.
    always_ff @(posedge clk_in) begin
        if (wr_line_en) begin
            tag_q[wr_index] <= wr_tag;
        end
        if (wr_word_en) begin
            data_q[wr_index][wr_offset] <= wr_word;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_word  = data_q[rd_index][rd_offset];
endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: lookup/fill FSM, fill counter, response regs.
// Optional hit/miss statistics outputs are built when ICACHE_STAT_EN is defined.
module icache
    import icache_pkg::*;
(
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          flush,
    input  logic          fetch_en,
    input  logic [31:0]   fetch_addr,
    output logic          fetch_rdy,
    output logic [31:0]   fetch_data,
    output logic          mem_en,
    output logic [31:0]   mem_addr,
    input  logic          mem_rdy,
    input  logic [31:0]   mem_data,
`ifdef ICACHE_STAT_EN
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count,
`endif
    output icache_state_e dbg_state
);
    // Memory handshake: mem_en/mem_addr are held until the cycle mem_rdy is
    // sampled high; mem_rdy is a one-cycle pulse that completes that word.
    icache_state_e           state_q, state_d;
    logic [OFFSET_WIDTH-1:0] count_q, count_d;
    logic [TAG_WIDTH-1:0]    base_tag_q, base_tag_d;
    logic [INDEX_WIDTH-1:0]  base_index_q, base_index_d;
    logic                    squash_q, squash_d;
    logic                    fetch_rdy_d;
    logic [31:0]             fetch_data_d;
    logic                    lookup, hit;
    logic                    rd_valid;
    logic [TAG_WIDTH-1:0]    rd_tag;
    logic [31:0]             rd_word;
    logic                    wr_word_en, wr_line_en;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^fetch_addr[1:0];

    icache_array u_array (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rd_index   (addr_index(fetch_addr)),
        .rd_offset  (addr_offset(fetch_addr)),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_word    (rd_word),
        .wr_word_en (wr_word_en),
        .wr_index   (base_index_q),
        .wr_offset  (count_q),
        .wr_word    (mem_data),
        .wr_line_en (wr_line_en),
        .wr_tag     (base_tag_q)
    );

    // squash_q swallows the re-lookup after a fill that a flush has orphaned.
    assign lookup = (state_q == IDLE) && fetch_en && !fetch_rdy && !flush && !squash_q;
    assign hit    = rd_valid && (rd_tag == addr_tag(fetch_addr));

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        base_tag_d   = base_tag_q;
        base_index_d = base_index_q;
        squash_d     = squash_q;
        fetch_rdy_d  = 1'b0;
        fetch_data_d = fetch_data;
        wr_word_en   = 1'b0;
        wr_line_en   = 1'b0;
        case (state_q)
            IDLE: begin
                squash_d = 1'b0;
                if (lookup) begin
                    if (hit) begin
                        fetch_rdy_d  = 1'b1;
                        fetch_data_d = rd_word;
                    end else begin
                        state_d      = FILL;
                        base_tag_d   = addr_tag(fetch_addr);
                        base_index_d = addr_index(fetch_addr);
                        count_d      = '0;
                    end
                end
            end
            FILL: begin
                if (flush) begin
                    squash_d = 1'b1;
                end
                if (mem_rdy) begin
                    wr_word_en = rdy_in && !rst_in;
                    count_d    = count_q + 1'b1;
                    if (&count_q) begin
                        wr_line_en = rdy_in && !rst_in;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            count_q      <= '0;
            base_tag_q   <= '0;
            base_index_q <= '0;
            squash_q     <= 1'b0;
            fetch_rdy    <= 1'b0;
            fetch_data   <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            count_q      <= count_d;
            base_tag_q   <= base_tag_d;
            base_index_q <= base_index_d;
            squash_q     <= squash_d;
            fetch_rdy    <= fetch_rdy_d;
            fetch_data   <= fetch_data_d;
        end
    end

`ifdef ICACHE_STAT_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rdy_in && lookup) begin
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end
`endif

    assign mem_en    = (state_q == FILL);
    assign mem_addr  = {base_tag_q, base_index_q, count_q, 2'b00};
    assign dbg_state = state_q;
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, conflict, flush during fill, stall and reset.
module tb_icache;
    import icache_pkg::*;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, flush, fetch_en;
    logic [31:0]   fetch_addr;
    logic          fetch_rdy;
    logic [31:0]   fetch_data;
    logic          mem_en;
    logic [31:0]   mem_addr;
    logic          mem_rdy;
    logic [31:0]   mem_data;
    icache_state_e dbg_state;
`ifdef ICACHE_STAT_EN
    logic [31:0]   hit_count, miss_count;
`endif

    int errors = 0;
    int checks = 0;

    // Memory model: auto responder (3 cycles per word) or manual pulses from a test.
    logic          mem_auto;
    logic          auto_rdy, man_rdy;
    logic [31:0]   auto_data, man_data;
    logic [31:0]   resp_addr;
    logic [31:0]   mem_log[$];
    logic [31:0]   exp_q[$];
    int            stable_viol = 0;

    assign mem_rdy  = auto_rdy | man_rdy;
    assign mem_data = auto_rdy ? auto_data : man_data;

    icache dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush      (flush),
        .fetch_en   (fetch_en),
        .fetch_addr (fetch_addr),
        .fetch_rdy  (fetch_rdy),
        .fetch_data (fetch_data),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdy    (mem_rdy),
        .mem_data   (mem_data),
`ifdef ICACHE_STAT_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .dbg_state  (dbg_state)
    );

    // Clock / reset
    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h1000_0000;
    endfunction

    always begin
        @(negedge clk_in);
        if (mem_auto && mem_en) begin
            resp_addr = mem_addr;
            mem_log.push_back(resp_addr);
            repeat (2) begin
                @(negedge clk_in);
                if (mem_en !== 1'b1 || mem_addr !== resp_addr) stable_viol++;
            end
            auto_data = mem_word(resp_addr);
            auto_rdy  = 1'b1;
            @(negedge clk_in);
            auto_rdy  = 1'b0;
            auto_data = '0;
        end
    end

    // Driver: hold fetch_en until fetch_rdy (optionally one extra cycle), then count stray pulses.
    task automatic do_fetch(input logic [31:0] a, input bit hold, output bit got,
                            output logic [31:0] d, output int lat, output int memc,
                            output int pulses);
        got = 1'b0; d = '0; lat = 0; memc = 0; pulses = 0;
        fetch_addr = a;
        fetch_en   = 1'b1;
        while (!got && lat < 300) begin
            @(negedge clk_in);
            lat++;
            if (mem_en) memc++;
            if (fetch_rdy) begin
                got = 1'b1; d = fetch_data; pulses = 1;
            end
        end
        if (got && hold) begin
            @(negedge clk_in);
            if (fetch_rdy) pulses++;
            if (mem_en) memc++;
        end
        fetch_en = 1'b0;
        repeat (2) begin
            @(negedge clk_in);
            if (fetch_rdy) pulses++;
            if (mem_en) memc++;
        end
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        checks++;
        if (fetch_rdy !== 1'b0 || fetch_data !== 32'h0) begin
            errors++; $display("FAIL reset_fetch: rdy=%b data=%h required 0/00000000", fetch_rdy, fetch_data);
        end
        checks++;
        if (mem_en !== 1'b0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_mem: en=%b addr=%h required 0/00000000", mem_en, mem_addr);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++; $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
        end
`ifdef ICACHE_STAT_EN
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++; $display("FAIL reset_stats: hit=%0d miss=%0d required 0/0", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_cold_miss;
        bit got; logic [31:0] d; int lat, memc, pulses;
        mem_log.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        do_fetch(32'h0, 1'b0, got, d, lat, memc, pulses);
        checks++;
        if (got !== 1'b1 || d !== 32'h1000_0000) begin
            errors++; $display("FAIL cold_data: got=%b data=%h required 1/10000000", got, d);
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL cold_pulses: got %0d required 1", pulses);
        end
        checks++;
        if (mem_log.size() !== 4) begin
            errors++; $display("FAIL cold_nreq: got %0d required 4", mem_log.size());
        end
        for (int i = 0; i < 4 && i < mem_log.size(); i++) begin
            checks++;
            if (mem_log[i] !== exp_q[i]) begin
                errors++; $display("FAIL cold_addr%0d: got %h required %h", i, mem_log[i], exp_q[i]);
            end
        end
        checks++;
        if (stable_viol !== 0) begin
            errors++; $display("FAIL cold_req_stable: violations %0d required 0", stable_viol);
        end
    endtask

    task automatic test_hit;
        bit got; logic [31:0] d; int lat, memc, pulses;
        do_fetch(32'h8, 1'b1, got, d, lat, memc, pulses);
        checks++;
        if (got !== 1'b1 || d !== 32'h1000_0008 || lat !== 1) begin
            errors++; $display("FAIL hit_data: got=%b data=%h lat=%0d required 1/10000008/1", got, d, lat);
        end
        checks++;
        if (memc !== 0) begin
            errors++; $display("FAIL hit_mem_en: mem_en cycles %0d required 0", memc);
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL hit_single_pulse: got %0d required 1", pulses);
        end
`ifdef ICACHE_STAT_EN
        checks++;
        if (hit_count !== 32'd2 || miss_count !== 32'd1) begin
            errors++; $display("FAIL stats: hit=%0d miss=%0d required 2/1", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_conflict;
        bit got; logic [31:0] d; int lat, memc, pulses;
        mem_log.delete();
        do_fetch(32'h100, 1'b0, got, d, lat, memc, pulses);
        checks++;
        if (got !== 1'b1 || d !== 32'h1000_0100) begin
            errors++; $display("FAIL conflict_data: got=%b data=%h required 1/10000100", got, d);
        end
        checks++;
        if (mem_log.size() !== 4 || mem_log[0] !== 32'h100 || mem_log[3] !== 32'h10C) begin
            errors++; $display("FAIL conflict_fill: n=%0d first=%h last=%h required 4/100/10c",
                               mem_log.size(), mem_log[0], mem_log[mem_log.size()-1]);
        end
        mem_log.delete();
        do_fetch(32'h0, 1'b0, got, d, lat, memc, pulses);
        checks++;
        if (got !== 1'b1 || d !== 32'h1000_0000 || mem_log.size() !== 4) begin
            errors++; $display("FAIL conflict_remiss: got=%b data=%h nreq=%0d required 1/10000000/4",
                               got, d, mem_log.size());
        end
    endtask

    task automatic test_flush_fill;
        bit got; logic [31:0] d; int lat, memc, pulses;
        int nrdy, cyc, rdys;
        mem_log.delete();
        nrdy = 0; cyc = 0; rdys = 0;
        fetch_addr = 32'h40;
        fetch_en   = 1'b1;
        while (nrdy < 2 && cyc < 200) begin
            @(negedge clk_in); #1;
            cyc++;
            if (fetch_rdy) rdys++;
            if (mem_rdy) nrdy++;
        end
        flush = 1'b1; fetch_en = 1'b0;
        @(negedge clk_in);
        flush = 1'b0;
        repeat (40) begin
            @(negedge clk_in);
            if (fetch_rdy) rdys++;
        end
        checks++;
        if (nrdy !== 2) begin
            errors++; $display("FAIL flush_wait: mem_rdy seen %0d required 2", nrdy);
        end
        checks++;
        if (rdys !== 0) begin
            errors++; $display("FAIL flush_no_resp: fetch_rdy pulses %0d required 0", rdys);
        end
        checks++;
        if (mem_log.size() !== 4 || mem_log[3] !== 32'h4C || dbg_state !== IDLE) begin
            errors++; $display("FAIL flush_fill_done: nreq=%0d state=%0d required 4/0", mem_log.size(), dbg_state);
        end
        do_fetch(32'h44, 1'b0, got, d, lat, memc, pulses);
        checks++;
        if (got !== 1'b1 || d !== 32'h1000_0044 || lat !== 1 || memc !== 0) begin
            errors++; $display("FAIL flush_then_hit: got=%b data=%h lat=%0d memc=%0d required 1/10000044/1/0",
                               got, d, lat, memc);
        end
    endtask

    task automatic test_stall_reset;
        bit got; logic [31:0] d; int lat, memc, pulses, cyc;
        mem_auto   = 1'b0;
        fetch_addr = 32'h80;
        fetch_en   = 1'b1;
        cyc = 0;
        while (!mem_en && cyc < 20) begin
            @(negedge clk_in);
            cyc++;
        end
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h80 || dbg_state !== FILL) begin
            errors++; $display("FAIL stall_start: en=%b addr=%h state=%0d required 1/80/1", mem_en, mem_addr, dbg_state);
        end
        man_data = mem_word(32'h80); man_rdy = 1'b1;
        @(negedge clk_in);
        man_rdy = 1'b0;
        checks++;
        if (mem_addr !== 32'h84) begin
            errors++; $display("FAIL stall_word1: addr=%h required 84", mem_addr);
        end
        rdy_in = 1'b0;
        man_data = 32'hDEAD_BEEF; man_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            man_rdy = 1'b0;
            checks++;
            if (mem_en !== 1'b1 || mem_addr !== 32'h84 || dbg_state !== FILL ||
                fetch_rdy !== 1'b0 || fetch_data !== 32'h1000_0044) begin
                errors++; $display("FAIL stall_hold%0d: en=%b addr=%h state=%0d rdy=%b data=%h required 1/84/1/0/10000044",
                                   i, mem_en, mem_addr, dbg_state, fetch_rdy, fetch_data);
            end
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (mem_addr !== 32'h84) begin
            errors++; $display("FAIL stall_release: addr=%h required 84", mem_addr);
        end
        man_data = mem_word(32'h84); man_rdy = 1'b1;
        @(negedge clk_in);
        man_rdy = 1'b0;
        checks++;
        if (mem_addr !== 32'h88) begin
            errors++; $display("FAIL stall_word2: addr=%h required 88", mem_addr);
        end
        rst_in = 1'b1; fetch_en = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        checks++;
        if (mem_en !== 1'b0 || mem_addr !== 32'h0 || dbg_state !== IDLE) begin
            errors++; $display("FAIL reset_mid_fill: en=%b addr=%h state=%0d required 0/0/0", mem_en, mem_addr, dbg_state);
        end
        mem_auto = 1'b1;
        mem_log.delete();
        do_fetch(32'h84, 1'b0, got, d, lat, memc, pulses);
        checks++;
        if (got !== 1'b1 || d !== 32'h1000_0084 || mem_log.size() !== 4 || mem_log[0] !== 32'h80) begin
            errors++; $display("FAIL reset_line_invalid: got=%b data=%h nreq=%0d required 1/10000084/4",
                               got, d, mem_log.size());
        end
        mem_log.delete();
        do_fetch(32'h40, 1'b0, got, d, lat, memc, pulses);
        checks++;
        if (got !== 1'b1 || d !== 32'h1000_0040 || mem_log.size() !== 4) begin
            errors++; $display("FAIL reset_clears_all: got=%b data=%h nreq=%0d required 1/10000040/4",
                               got, d, mem_log.size());
        end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; fetch_en = 1'b0; fetch_addr = '0;
        mem_auto = 1'b1; auto_rdy = 1'b0; man_rdy = 1'b0; auto_data = '0; man_data = '0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_fill();
        test_stall_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
